mulf_seq: RTL and testbench

Parametrised, sequential IEEE-754-style floating-point multiplier. It is the clocked successor to the combinational mulf.
- Generic in exponent and mantissa width.
- Iterative shift-add significand multiply, one bit per cycle.
- Round-to-nearest-even, special-value handling and exception flags.
- Valid/ready handshakes on both sides, so it can sit on the ALU issue path without combinational depth concerns.

---
 rtl/mulf_seq_pkg.sv | 18 +
 rtl/mulf_seq_fp_unpack.sv | 31 +++
 rtl/mulf_seq.sv | 188 ++++++++++++++++++
 tb/tb_mulf_seq.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mulf_seq_pkg.sv
// Shared definitions for the sequential floating-point multiplier:
// FSM state encoding and the bit positions of the exception flags.
package mulf_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    NORM = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam int FLAGS_W        = 4;
  localparam int FLAG_INVALID   = 3;
  localparam int FLAG_OVERFLOW  = 2;
  localparam int FLAG_UNDERFLOW = 1;
  localparam int FLAG_INEXACT   = 0;

endpackage

// File: rtl/mulf_seq_fp_unpack.sv
// Combinational field decoder for one floating-point operand. Subnormals
// are flushed to zero, so any operand with a zero exponent reports is_zero
// and a zero significand.
module fp_unpack #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic [EXP_W+MAN_W:0] op_i,
  output logic                 sign_o,
  output logic [EXP_W-1:0]     exp_o,
  output logic [MAN_W:0]       sig_o,
  output logic                 is_zero_o,
  output logic                 is_inf_o,
  output logic                 is_nan_o
);

  logic [MAN_W-1:0] frac;
  logic             expZero;
  logic             expOnes;

  assign sign_o    = op_i[EXP_W+MAN_W];
  assign exp_o     = op_i[EXP_W+MAN_W-1 -: EXP_W];
  assign frac      = op_i[MAN_W-1:0];
  assign expZero   = (exp_o == '0);
  assign expOnes   = &exp_o;
  assign sig_o     = expZero ? '0 : {1'b1, frac};
  assign is_zero_o = expZero;
  assign is_inf_o  = expOnes & ~(|frac);
  assign is_nan_o  = expOnes & (|frac);

endmodule

// File: rtl/mulf_seq.sv
// Sequential floating-point multiplier: one significand bit per cycle
// shift-add, round-to-nearest-even, special values and exception flags,
// with valid/ready handshakes on both the operand and result sides.
module mulf_seq
  import mulf_seq_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] a,
  input  logic [EXP_W+MAN_W:0] b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] s,
  output logic [FLAGS_W-1:0]   flags
);

  localparam int W      = EXP_W + MAN_W + 1;
  localparam int SIG_W  = MAN_W + 1;
  localparam int PROD_W = 2 * SIG_W;
  localparam int E_W    = EXP_W + 2;
  localparam int CNT_W  = $clog2(SIG_W + 1);

  localparam logic signed [E_W-1:0] BIAS_E    = E_W'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [E_W-1:0] EXP_MAX_E = E_W'((1 << EXP_W) - 1);
  localparam logic signed [E_W-1:0] ZERO_E    = '0;
  localparam logic [W-1:0]          QNAN      = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  // Operand decode
  logic             signA, signB;
  logic [EXP_W-1:0] expA, expB;
  logic [MAN_W:0]   sigA, sigB;
  logic             zeroA, zeroB, infA, infB, nanA, nanB;

  fp_unpack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_unpack_a (
    .op_i(a), .sign_o(signA), .exp_o(expA), .sig_o(sigA),
    .is_zero_o(zeroA), .is_inf_o(infA), .is_nan_o(nanA)
  );

  fp_unpack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_unpack_b (
    .op_i(b), .sign_o(signB), .exp_o(expB), .sig_o(sigB),
    .is_zero_o(zeroB), .is_inf_o(infB), .is_nan_o(nanB)
  );

  // Registered state
  state_e                  state_q;
  logic                    in_ready_q, out_valid_q;
  logic [W-1:0]            s_q;
  logic [FLAGS_W-1:0]      flags_q;
  logic                    sign_q;
  logic signed [E_W-1:0]   exp_q;
  logic [PROD_W-1:0]       prod_q, mcand_q;
  logic [SIG_W-1:0]        mplier_q;
  logic [CNT_W-1:0]        cnt_q;

  // Combinational next values
  logic                    sign_d;
  logic                    spec_hit_d;
  logic [W-1:0]            spec_s_d;
  logic [FLAGS_W-1:0]      spec_flags_d;
  logic signed [E_W-1:0]   exp_sum_d;
  logic [PROD_W-2:0]       norm_d;
  logic [MAN_W-1:0]        frac_d;
  logic                    guard_d, sticky_d, rnd_up_d;
  logic [MAN_W:0]          rnd_sum_d;
  logic signed [E_W-1:0]   exp_n_d;
  logic [W-1:0]            res_s_d;
  logic [FLAGS_W-1:0]      res_flags_d;

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign s         = s_q;
  assign flags     = flags_q;

  // Classify the incoming operand pair: special result (in priority order) and biased exponent sum
  always_comb begin
    sign_d       = signA ^ signB;
    spec_hit_d   = 1'b1;
    spec_s_d     = '0;
    spec_flags_d = '0;
    exp_sum_d    = $signed({2'b00, expA}) + $signed({2'b00, expB}) - BIAS_E;
    if (nanA || nanB || (infA && zeroB) || (zeroA && infB)) begin
      spec_s_d                   = QNAN;
      spec_flags_d[FLAG_INVALID] = 1'b1;
    end else if (infA || infB) begin
      spec_s_d = {sign_d, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (zeroA || zeroB) begin
      spec_s_d = {sign_d, {(W-1){1'b0}}};
    end else begin
      spec_hit_d = 1'b0;
    end
  end

  // Normalise, round to nearest even and detect overflow/underflow of the finished product
  always_comb begin
    norm_d      = prod_q[PROD_W-1] ? prod_q[PROD_W-2:0] : {prod_q[PROD_W-3:0], 1'b0};
    frac_d      = norm_d[PROD_W-2 -: MAN_W];
    guard_d     = norm_d[MAN_W];
    sticky_d    = |norm_d[MAN_W-1:0];
    rnd_up_d    = guard_d & (sticky_d | frac_d[0]);
    rnd_sum_d   = {1'b0, frac_d} + {{MAN_W{1'b0}}, rnd_up_d};
    exp_n_d     = exp_q
                + $signed({{(E_W-1){1'b0}}, prod_q[PROD_W-1]})
                + $signed({{(E_W-1){1'b0}}, rnd_sum_d[MAN_W]});
    res_s_d     = {sign_q, exp_n_d[EXP_W-1:0], rnd_sum_d[MAN_W-1:0]};
    res_flags_d = '0;
    if (exp_n_d >= EXP_MAX_E) begin
      res_s_d                     = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      res_flags_d[FLAG_OVERFLOW]  = 1'b1;
      res_flags_d[FLAG_INEXACT]   = 1'b1;
    end else if (exp_n_d <= ZERO_E) begin
      res_s_d                     = {sign_q, {(W-1){1'b0}}};
      res_flags_d[FLAG_UNDERFLOW] = 1'b1;
      res_flags_d[FLAG_INEXACT]   = 1'b1;
    end else begin
      res_flags_d[FLAG_INEXACT]   = guard_d | sticky_d;
    end
  end

  // Control FSM with datapath registers: accept, shift-add multiply, normalise, hold result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      s_q         <= '0;
      flags_q     <= '0;
      sign_q      <= 1'b0;
      exp_q       <= '0;
      prod_q      <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      cnt_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            sign_q     <= sign_d;
            in_ready_q <= 1'b0;
            if (spec_hit_d) begin
              s_q         <= spec_s_d;
              flags_q     <= spec_flags_d;
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end else begin
              exp_q    <= exp_sum_d;
              mcand_q  <= {{SIG_W{1'b0}}, sigA};
              mplier_q <= sigB;
              prod_q   <= '0;
              cnt_q    <= '0;
              state_q  <= MUL;
            end
          end
        end
        MUL: begin
          prod_q   <= prod_q + (mplier_q[0] ? mcand_q : '0);
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(SIG_W - 1)) begin
            state_q <= NORM;
          end
        end
        NORM: begin
          s_q         <= res_s_d;
          flags_q     <= res_flags_d;
          out_valid_q <= 1'b1;
          state_q     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mulf_seq.sv
// Testbench for mulf_seq: directed cases, backpressure, asynchronous reset
// and randomised operands compared with an arithmetic reference model, on
// both a single-precision and a half-precision instance.
module tb_mulf_seq;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  logic        inValid, inReady, outValid, outReady;
  logic [31:0] aIn, bIn, sOut;
  logic [3:0]  flagsOut;

  logic        hInValid, hInReady, hOutValid, hOutReady;
  logic [15:0] hA, hB, hS;
  logic [3:0]  hFlags;

  int errors = 0;
  int checks = 0;
  bit selHalf = 1'b0;

  logic        curOutValid, curInReady;
  logic [31:0] curS;
  logic [3:0]  curFlags;

  assign curOutValid = selHalf ? hOutValid : outValid;
  assign curInReady  = selHalf ? hInReady  : inReady;
  assign curS        = selHalf ? {16'h0, hS} : sOut;
  assign curFlags    = selHalf ? hFlags : flagsOut;

  mulf_seq dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(inValid), .in_ready(inReady), .a(aIn), .b(bIn),
    .out_valid(outValid), .out_ready(outReady), .s(sOut), .flags(flagsOut)
  );

  mulf_seq #(.EXP_W(5), .MAN_W(10)) dutH (
    .clk(clk), .rst_n(rst_n),
    .in_valid(hInValid), .in_ready(hInReady), .a(hA), .b(hB),
    .out_valid(hOutValid), .out_ready(hOutReady), .s(hS), .flags(hFlags)
  );

  // Reference model: exact integer product, then round-to-nearest-even by remainder comparison
  function automatic void refModel(input int ew, input int mw, input logic [31:0] av,
                                   input logic [31:0] bv, output logic [31:0] sExp,
                                   output logic [3:0] fExp, output int latExp);
    longint unsigned emax, bias, ea, eb, fa, fb, p, q, rem, halfv, fmask, signBit;
    longint e;
    int sh;
    bit sa, sb;
    fmask   = (64'd1 << mw) - 1;
    emax    = (64'd1 << ew) - 1;
    bias    = (64'd1 << (ew - 1)) - 1;
    sa      = av[ew+mw];
    sb      = bv[ew+mw];
    ea      = ({32'h0, av} >> mw) & emax;
    eb      = ({32'h0, bv} >> mw) & emax;
    fa      = {32'h0, av} & fmask;
    fb      = {32'h0, bv} & fmask;
    signBit = longint'(sa ^ sb) << (ew + mw);
    latExp  = 1;
    fExp    = 4'b0000;
    if ((ea == emax && fa != 0) || (eb == emax && fb != 0) ||
        (ea == emax && eb == 0) || (eb == emax && ea == 0)) begin
      sExp = 32'((emax << mw) | (64'd1 << (mw - 1)));
      fExp = 4'b1000;
    end else if (ea == emax || eb == emax) begin
      sExp = 32'(signBit | (emax << mw));
    end else if (ea == 0 || eb == 0) begin
      sExp = 32'(signBit);
    end else begin
      latExp = mw + 3;
      p  = (fa | (64'd1 << mw)) * (fb | (64'd1 << mw));
      e  = longint'(ea + eb - bias);
      sh = mw;
      if (p >= (64'd1 << (2 * mw + 1))) begin
        sh = mw + 1;
        e  = e + 1;
      end
      q     = p >> sh;
      rem   = p - (q << sh);
      halfv = 64'd1 << (sh - 1);
      if (rem > halfv || (rem == halfv && (q & 1) != 0)) q = q + 1;
      if (q == (64'd1 << (mw + 1))) begin
        q = q >> 1;
        e = e + 1;
      end
      if (e >= longint'(emax)) begin
        sExp = 32'(signBit | (emax << mw));
        fExp = 4'b0101;
      end else if (e <= 0) begin
        sExp = 32'(signBit);
        fExp = 4'b0011;
      end else begin
        sExp = 32'(signBit | (longint'(e) << mw) | (q & fmask));
        fExp = {3'b000, rem != 0};
      end
    end
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Present one operand pair at the current cycle; returns just after the accepting edge
  task automatic applyStimulus(input bit half, input logic [31:0] av, input logic [31:0] bv);
    selHalf = half;
    if (half) begin
      hA = av[15:0]; hB = bv[15:0]; hInValid = 1'b1;
    end else begin
      aIn = av; bIn = bv; inValid = 1'b1;
    end
    @(posedge clk); #1;
    inValid = 1'b0; hInValid = 1'b0;
    aIn = $urandom; bIn = $urandom; hA = 16'($urandom); hB = 16'($urandom);
  endtask

  // Count edges from acceptance (accepting edge = 1) until out_valid, bounded
  task automatic waitResult(output int edges, output bit readyLow);
    edges = 1;
    readyLow = 1'b1;
    while (!curOutValid && edges < 200) begin
      if (curInReady) readyLow = 1'b0;
      @(posedge clk); #1;
      edges++;
    end
    if (curInReady) readyLow = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] expS, input logic [3:0] expF,
                             input int expLat, input int edges, input bit readyLow);
    check({tag, "_s"}, curS, expS);
    check({tag, "_flags"}, {28'h0, curFlags}, {28'h0, expF});
    check({tag, "_latency"}, 32'(edges), 32'(expLat));
    check({tag, "_busy"}, {31'h0, readyLow}, 32'd1);
  endtask

  // Full transaction with the consumer always ready, then confirm return to idle
  task automatic runOp(input string tag, input bit half, input logic [31:0] av,
                       input logic [31:0] bv, input logic [31:0] expS,
                       input logic [3:0] expF, input int expLat);
    int edges;
    bit readyLow;
    selHalf = half;
    check({tag, "_ready_idle"}, {31'h0, curInReady}, 32'd1);
    applyStimulus(half, av, bv);
    waitResult(edges, readyLow);
    checkOutput(tag, expS, expF, expLat, edges, readyLow);
    @(posedge clk); #1;
    check({tag, "_release"}, {30'h0, curOutValid, curInReady}, 32'b01);
  endtask

  initial begin
    logic [31:0] ra, rb, es;
    logic [3:0]  ef;
    int          el, edges;
    bit          readyLow;

    rst_n = 1'b1;
    inValid = 1'b0; hInValid = 1'b0;
    aIn = '0; bIn = '0; hA = '0; hB = '0;
    outReady = 1'b1; hOutReady = 1'b1;
    #2 rst_n = 1'b0;
    #10;
    check("reset_ready", {31'h0, inReady}, 32'd1);
    check("reset_valid", {31'h0, outValid}, 32'd0);
    check("reset_s", sOut, 32'h0);
    check("reset_flags", {28'h0, flagsOut}, 32'h0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    runOp("one_x_five",  0, 32'h3F800000, 32'h40A00000, 32'h40A00000, 4'b0000, 26);
    runOp("neg5_x_3",    0, 32'hC0A00000, 32'h40400000, 32'hC1700000, 4'b0000, 26);
    runOp("tie_even",    0, 32'hC0400000, 32'hC0666666, 32'h412CCCCC, 4'b0001, 26);
    runOp("overflow",    0, 32'h7F000000, 32'h40000000, 32'h7F800000, 4'b0101, 26);
    runOp("inf_x_zero",  0, 32'h7F800000, 32'h00000000, 32'h7FC00000, 4'b1000, 1);
    runOp("underflow",   0, 32'h00800000, 32'h00800000, 32'h00000000, 4'b0011, 26);
    runOp("inf_x_neg2",  0, 32'h7F800000, 32'hC0000000, 32'hFF800000, 4'b0000, 1);
    runOp("nan_x_one",   0, 32'h7F812345, 32'h3F800000, 32'h7FC00000, 4'b1000, 1);
    runOp("negz_x_five", 0, 32'h80000000, 32'h40A00000, 32'h80000000, 4'b0000, 1);
    runOp("subn_flush",  0, 32'h00000001, 32'h40A00000, 32'h00000000, 4'b0000, 1);
    runOp("half_1p5_x2", 1, 32'h00003E00, 32'h00004000, 32'h00004200, 4'b0000, 13);

    // Backpressure: result held while the consumer stalls and new operands wait
    selHalf = 1'b0;
    outReady = 1'b0;
    applyStimulus(0, 32'h3F800000, 32'h40400000);
    waitResult(edges, readyLow);
    checkOutput("bp_first", 32'h40400000, 4'b0000, 26, edges, readyLow);
    aIn = 32'h40000000; bIn = 32'h40000000; inValid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check($sformatf("bp_hold_valid_%0d", k), {31'h0, outValid}, 32'd1);
      check($sformatf("bp_hold_s_%0d", k), sOut, 32'h40400000);
      check($sformatf("bp_hold_flags_%0d", k), {28'h0, flagsOut}, 32'h0);
      check($sformatf("bp_hold_ready_%0d", k), {31'h0, inReady}, 32'd0);
    end
    outReady = 1'b1;
    @(posedge clk); #1;
    check("bp_handshake", {30'h0, outValid, inReady}, 32'b01);
    @(posedge clk); #1;
    check("bp_accept", {30'h0, outValid, inReady}, 32'b00);
    inValid = 1'b0;
    waitResult(edges, readyLow);
    checkOutput("bp_second", 32'h40800000, 4'b0000, 26, edges, readyLow);
    @(posedge clk); #1;

    // Asynchronous reset in the middle of the multiply phase
    applyStimulus(0, 32'h3F800000, 32'h40A00000);
    repeat (9) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("rst_mid_valid", {31'h0, outValid}, 32'd0);
    check("rst_mid_ready", {31'h0, inReady}, 32'd1);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    runOp("after_reset", 0, 32'h3F800000, 32'h40A00000, 32'h40A00000, 4'b0000, 26);

    // Randomised single-precision operands, half of them with exponents near the bias
    for (int i = 0; i < 40; i++) begin
      ra = $urandom; rb = $urandom;
      if (i % 2 == 1) begin
        ra[30:23] = 8'(107 + $urandom_range(0, 40));
        rb[30:23] = 8'(107 + $urandom_range(0, 40));
      end
      refModel(8, 23, ra, rb, es, ef, el);
      runOp($sformatf("rand32_%0d", i), 0, ra, rb, es, ef, el);
    end

    // Randomised half-precision operands
    for (int i = 0; i < 20; i++) begin
      ra = {16'h0, 16'($urandom)}; rb = {16'h0, 16'($urandom)};
      if (i % 2 == 1) begin
        ra[14:10] = 5'(11 + $urandom_range(0, 8));
        rb[14:10] = 5'(11 + $urandom_range(0, 8));
      end
      refModel(5, 10, ra, rb, es, ef, el);
      runOp($sformatf("rand16_%0d", i), 1, ra, rb, es, ef, el);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
